// File: rtl/mist_dump_ctrl.sv
// Capture-window sequencer for the MiST harness: counts VS frames, waits
// for ROM download when asked, and strobes dump enable/start/stop.
module mist_dump_ctrl #(
    parameter logic [31:0] START_FRAME = 32'd0,
    parameter logic [31:0] FRAME_LEN   = 32'd0,
    parameter bit          LOADROM     = 1'b0,
    parameter logic [15:0] GUARD       = 16'd1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vs,
    input  logic        downloading,
    output logic [31:0] frame_cnt,
    output logic        dump_en,
    output logic        dump_on,
    output logic        dump_off,
    output logic [1:0]  st
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] frame_n;
    logic [31:0] len_cnt;
    logic [31:0] len_n;
    logic        en_n;
    logic        on_n;
    logic        off_n;
    logic        vs_l;
    logic        dl_l;
    logic [15:0] guard_cnt;
    logic        vs_fall;
    logic        dl_fall;
    logic        dl_rise;
    logic        guard_ok;

    assign vs_fall  = vs_l & ~vs;
    assign dl_fall  = dl_l & ~downloading;
    assign dl_rise  = ~dl_l & downloading;
    assign guard_ok = (guard_cnt == GUARD);
    assign st       = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            frame_cnt <= '0;
            len_cnt   <= '0;
            dump_en   <= 1'b0;
            dump_on   <= 1'b0;
            dump_off  <= 1'b0;
            vs_l      <= 1'b1;
            dl_l      <= 1'b0;
            guard_cnt <= '0;
        end else begin
            state     <= state_n;
            frame_cnt <= frame_n;
            len_cnt   <= len_n;
            dump_en   <= en_n;
            dump_on   <= on_n;
            dump_off  <= off_n;
            vs_l      <= vs;
            dl_l      <= downloading;
            if (!guard_ok)
                guard_cnt <= guard_cnt + 16'd1;
        end
    end

    always_comb begin
        state_n = state;
        frame_n = frame_cnt;
        len_n   = len_cnt;
        en_n    = dump_en;
        on_n    = 1'b0;
        off_n   = 1'b0;
        unique case (state)
            IDLE: begin
                en_n = 1'b0;
                // early download edges right after reset are glitches
                if (!LOADROM || (dl_fall && guard_ok)) begin
                    state_n = ARMED;
                    frame_n = '0;
                end
            end
            ARMED: begin
                if (dl_rise) begin
                    state_n = IDLE;
                end else if (vs_fall) begin
                    frame_n = frame_cnt + 32'd1;
                    if (frame_cnt == START_FRAME) begin
                        state_n = DUMP;
                        en_n    = 1'b1;
                        on_n    = 1'b1;
                        len_n   = '0;
                    end
                end
            end
            DUMP: begin
                if (dl_rise) begin
                    state_n = IDLE;
                    en_n    = 1'b0;
                    off_n   = 1'b1;
                end else if (vs_fall) begin
                    frame_n = frame_cnt + 32'd1;
                    if (FRAME_LEN != 32'd0 &&
                        len_cnt == FRAME_LEN - 32'd1) begin
                        state_n = DONE;
                        en_n    = 1'b0;
                        off_n   = 1'b1;
                    end else begin
                        len_n = len_cnt + 32'd1;
                    end
                end
            end
            DONE: begin
                if (dl_rise)
                    state_n = IDLE;
                else if (vs_fall)
                    frame_n = frame_cnt + 32'd1;
            end
            default: begin
                state_n = IDLE;
                en_n    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mist_dump_ctrl.sv
// Directed bench for mist_dump_ctrl: three parameterisations share one
// stimulus set; each phase checks the instance it targets.
module tb_mist_dump_ctrl;

    logic clk;
    logic rst_n;
    logic vs;
    logic downloading;

    logic [31:0] u0_cnt, u1_cnt, u2_cnt;
    logic        u0_en, u1_en, u2_en;
    logic        u0_on, u1_on, u2_on;
    logic        u0_off, u1_off, u2_off;
    logic [1:0]  u0_st, u1_st, u2_st;

    int n_tests = 0;
    int n_fail  = 0;
    int u2_ons  = 0;
    int u2_offs = 0;
    int both_hi = 0;
    int offs_snap;

    mist_dump_ctrl #(
        .START_FRAME(32'd3), .FRAME_LEN(32'd2),
        .LOADROM(1'b0), .GUARD(16'd1000)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading),
        .frame_cnt(u0_cnt), .dump_en(u0_en), .dump_on(u0_on),
        .dump_off(u0_off), .st(u0_st)
    );

    mist_dump_ctrl #(
        .START_FRAME(32'd0), .FRAME_LEN(32'd0),
        .LOADROM(1'b1), .GUARD(16'd100)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading),
        .frame_cnt(u1_cnt), .dump_en(u1_en), .dump_on(u1_on),
        .dump_off(u1_off), .st(u1_st)
    );

    mist_dump_ctrl #(
        .START_FRAME(32'd0), .FRAME_LEN(32'd0),
        .LOADROM(1'b0), .GUARD(16'd1000)
    ) u2 (
        .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading),
        .frame_cnt(u2_cnt), .dump_en(u2_en), .dump_on(u2_on),
        .dump_off(u2_off), .st(u2_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (u2_on) u2_ons++;
        if (u2_off) u2_offs++;
        if ((u0_on && u0_off) || (u1_on && u1_off) || (u2_on && u2_off))
            both_hi++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        vs = 1'b0;
        cyc(1);
        vs = 1'b1;
        cyc(2);
    endtask

    initial begin
        rst_n       = 1'b0;
        vs          = 1'b1;
        downloading = 1'b0;
        #12;
        check("rst_st", 32'(u0_st), 32'd0);
        check("rst_cnt", u0_cnt, 32'd0);
        check("rst_out", {29'd0, u0_en, u0_on, u0_off}, 32'd0);
        rst_n = 1'b1;
        cyc(1);
        check("arm_st", 32'(u0_st), 32'd1);
        check("idle_u1", 32'(u1_st), 32'd0);

        // START_FRAME=3, FRAME_LEN=2 window
        for (int i = 1; i <= 6; i++) begin
            vs = 1'b0;
            cyc(1);
            check("t1_cnt", u0_cnt, 32'(i));
            check("t1_on", 32'(u0_on), 32'(i == 4));
            check("t1_off", 32'(u0_off), 32'(i == 6));
            check("t1_en", 32'(u0_en), 32'(i == 4 || i == 5));
            vs = 1'b1;
            cyc(1);
            check("t1_pulse", {30'd0, u0_on, u0_off}, 32'd0);
            cyc(1);
        end
        check("t1_done", 32'(u0_st), 32'd3);
        check("t1_fc", u0_cnt, 32'd6);

        // open-ended window runs to 100 frames
        for (int i = 7; i <= 100; i++) frame();
        check("t3_en", 32'(u2_en), 32'd1);
        check("t3_st", 32'(u2_st), 32'd2);
        check("t3_cnt", u2_cnt, 32'd100);
        check("t3_ons", 32'(u2_ons), 32'd1);
        check("t3_offs", 32'(u2_offs), 32'd0);
        check("done_cnt", u0_cnt, 32'd100);

        // abort coinciding with a vs fall
        vs          = 1'b0;
        downloading = 1'b1;
        cyc(1);
        check("ab_st", 32'(u2_st), 32'd0);
        check("ab_off", 32'(u2_off), 32'd1);
        check("ab_en", 32'(u2_en), 32'd0);
        check("ab_cnt", u2_cnt, 32'd100);
        check("ab_done", 32'(u0_st), 32'd0);

        // async reset mid-window
        vs          = 1'b1;
        downloading = 1'b0;
        rst_n       = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        vs = 1'b0;
        cyc(1);
        vs = 1'b1;
        check("rw_open", {30'd0, u2_en, u2_on}, 32'd3);
        offs_snap = u2_offs;
        #3;
        rst_n = 1'b0;
        #1;
        check("rw_st", 32'(u2_st), 32'd0);
        check("rw_cnt", u2_cnt, 32'd0);
        check("rw_out", {29'd0, u2_en, u2_on, u2_off}, 32'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        check("rw_rearm", 32'(u2_st), 32'd1);
        check("rw_nooff", 32'(u2_offs), 32'(offs_snap));

        // frame counter wrap before START_FRAME=0 match
        force u2.frame_cnt = 32'hFFFF_FFFF;
        cyc(1);
        release u2.frame_cnt;
        check("wr_pre", u2_cnt, 32'hFFFF_FFFF);
        vs = 1'b0;
        cyc(1);
        check("wr_cnt", u2_cnt, 32'd0);
        check("wr_st", 32'(u2_st), 32'd1);
        check("wr_en", 32'(u2_en), 32'd0);
        vs = 1'b1;
        cyc(2);
        vs = 1'b0;
        cyc(1);
        check("wr_on", 32'(u2_on), 32'd1);
        check("wr_open", 32'(u2_st), 32'd2);
        check("wr_cnt1", u2_cnt, 32'd1);
        vs = 1'b1;

        // LOADROM=1, GUARD=100
        rst_n = 1'b0;
        cyc(1);
        rst_n       = 1'b1;
        downloading = 1'b1;
        cyc(49);
        downloading = 1'b0;
        cyc(1);
        check("lr_early", 32'(u1_st), 32'd0);
        downloading = 1'b1;
        cyc(248);
        check("lr_wait", 32'(u1_st), 32'd0);
        downloading = 1'b0;
        vs          = 1'b0;
        cyc(1);
        check("lr_arm", 32'(u1_st), 32'd1);
        check("lr_cnt", u1_cnt, 32'd0);
        check("lr_en", 32'(u1_en), 32'd0);
        vs = 1'b1;
        cyc(2);
        vs = 1'b0;
        cyc(1);
        check("lr_on", 32'(u1_on), 32'd1);
        check("lr_cnt1", u1_cnt, 32'd1);
        vs = 1'b1;
        cyc(2);

        check("on_off_excl", 32'(both_hi), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
